// File: rtl/ula_controller_pkg.sv
// rtl/ula_controller_pkg.sv - shared types and constants for the ULA controller
//
// Holds the controller state enum, the bit offsets of each field inside the
// 36-bit instruction word, and the default matrix geometry (N x N, DW bits).
package ula_controller_pkg;

    localparam int N_DEF   = 5;
    localparam int DW_DEF  = 8;

    localparam int INSTR_W = 36;
    localparam int OPC_LSB = 0;   // [3:0]   opcode
    localparam int ESC_LSB = 4;   // [11:4]  escalar
    localparam int BA_LSB  = 12;  // [19:12] base_a
    localparam int BB_LSB  = 20;  // [27:20] base_b
    localparam int BR_LSB  = 28;  // [35:28] base_r

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        EXEC   = 3'd2,
        WAIT   = 3'd3,
        STORE  = 3'd4,
        FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/ula_controller_row_packer.sv
// rtl/ula_controller_row_packer.sv - N x N matrix register with row-wise or whole-matrix load
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears the matrix)
//   row_we_i     write row_data_i into row row_idx_i
//   row_idx_i    row index, row r occupies bits [r*N*DW +: N*DW]
//   row_data_i   one row, element j at [j*DW +: DW]
//   mat_we_i     load the whole matrix from mat_data_i (wins over row_we_i)
//   mat_data_i   full matrix input
//   mat_o        registered matrix
module ula_row_packer #(
    parameter int N    = 5,
    parameter int DW   = 8,
    parameter int IDXW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                row_we_i,
    input  logic [IDXW-1:0]     row_idx_i,
    input  logic [N*DW-1:0]     row_data_i,
    input  logic                mat_we_i,
    input  logic [N*N*DW-1:0]   mat_data_i,
    output logic [N*N*DW-1:0]   mat_o
);

    localparam int RW = N * DW;

    logic [N*N*DW-1:0] mat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q <= '0;
        end else if (mat_we_i) begin
            mat_q <= mat_data_i;
        end else if (row_we_i) begin
            for (int r = 0; r < N; r++) begin
                if (row_idx_i == IDXW'(r)) begin
                    mat_q[r*RW +: RW] <= row_data_i;
                end
            end
        end
    end

    assign mat_o = mat_q;

endmodule

// File: rtl/ula_controller.sv
// rtl/ula_controller.sv - sequences row loads, a ULA operation and row stores for one instruction
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    instruction handshake, instr = {base_r, base_b, base_a, escalar, opcode}
//   mem_addr/mem_rd/mem_wr     row memory address and strobes (read data valid one cycle after mem_rd)
//   mem_rdata/mem_wdata        one row (N*DW bits)
//   ula_opcode/ula_escalar     operation controls, passed through undecoded
//   ula_start/ula_done         start held until done is sampled
//   ula_matrizA/B              operand matrices, ula_matriz_resultante result matrix
//   busy/op_done/op_err        status; op_done and op_err are single-cycle pulses
module ula_controller
    import ula_controller_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr,
    output logic [7:0]           mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    input  logic [N*DW-1:0]      mem_rdata,
    output logic [N*DW-1:0]      mem_wdata,
    output logic [3:0]           ula_opcode,
    output logic [7:0]           ula_escalar,
    output logic                 ula_start,
    output logic [N*N*DW-1:0]    ula_matrizA,
    output logic [N*N*DW-1:0]    ula_matrizB,
    input  logic [N*N*DW-1:0]    ula_matriz_resultante,
    input  logic                 ula_done,
    output logic                 busy,
    output logic                 op_done,
    output logic                 op_err
);

    localparam int RW   = N * DW;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int CW   = $clog2(2 * N + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t          state_q;
    logic [3:0]      opcode_q;
    logic [7:0]      escalar_q;
    logic [7:0]      base_a_q;
    logic [7:0]      base_b_q;
    logic [7:0]      base_r_q;
    logic [7:0]      mem_addr_q;
    logic            mem_rd_q;
    logic            mem_wr_q;
    logic            ula_start_q;
    logic            op_done_q;
    logic            op_err_q;
    logic [CW-1:0]   rd_cnt_q;    // reads issued so far
    logic [CW-1:0]   cap_cnt_q;   // rows captured so far
    logic            rd_vld_q;    // mem_rdata carries a row this cycle
    logic [IDXW-1:0] st_idx_q;
    logic [TW-1:0]   tmr_q;

    logic [7:0]      rd_addr_d;
    logic            a_we_d;
    logic            b_we_d;
    logic            r_we_d;
    logic [IDXW-1:0] a_idx_d;
    logic [IDXW-1:0] b_idx_d;
    logic [N*N*DW-1:0] res_mat;

    // Reads 0..N-1 come from base_a, N..2N-1 from base_b; 8-bit add wraps.
    always_comb begin
        rd_addr_d = 8'd0;
        if (rd_cnt_q < CW'(N)) begin
            rd_addr_d = base_a_q + 8'(rd_cnt_q);
        end else begin
            rd_addr_d = base_b_q + 8'(rd_cnt_q - CW'(N));
        end
    end

    always_comb begin
        a_we_d  = (state_q == LOAD) && rd_vld_q && (cap_cnt_q < CW'(N));
        b_we_d  = (state_q == LOAD) && rd_vld_q && (cap_cnt_q >= CW'(N));
        a_idx_d = IDXW'(cap_cnt_q);
        b_idx_d = IDXW'(cap_cnt_q - CW'(N));
        r_we_d  = (state_q == EXEC) && ula_done;
    end

    ula_row_packer #(.N(N), .DW(DW), .IDXW(IDXW)) u_pack_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_we_i   (a_we_d),
        .row_idx_i  (a_idx_d),
        .row_data_i (mem_rdata),
        .mat_we_i   (1'b0),
        .mat_data_i ('0),
        .mat_o      (ula_matrizA)
    );

    ula_row_packer #(.N(N), .DW(DW), .IDXW(IDXW)) u_pack_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_we_i   (b_we_d),
        .row_idx_i  (b_idx_d),
        .row_data_i (mem_rdata),
        .mat_we_i   (1'b0),
        .mat_data_i ('0),
        .mat_o      (ula_matrizB)
    );

    // Result is captured whole in the cycle ula_done is sampled.
    ula_row_packer #(.N(N), .DW(DW), .IDXW(IDXW)) u_pack_r (
        .clk        (clk),
        .rst_n      (rst_n),
        .row_we_i   (1'b0),
        .row_idx_i  ('0),
        .row_data_i ('0),
        .mat_we_i   (r_we_d),
        .mat_data_i (ula_matriz_resultante),
        .mat_o      (res_mat)
    );

    // Row of the captured result selected by the store index.
    always_comb begin
        mem_wdata = '0;
        for (int r = 0; r < N; r++) begin
            if (st_idx_q == IDXW'(r)) begin
                mem_wdata = res_mat[r*RW +: RW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            escalar_q   <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_r_q    <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            ula_start_q <= 1'b0;
            op_done_q   <= 1'b0;
            op_err_q    <= 1'b0;
            rd_cnt_q    <= '0;
            cap_cnt_q   <= '0;
            rd_vld_q    <= 1'b0;
            st_idx_q    <= '0;
            tmr_q       <= '0;
        end else begin
            op_done_q <= 1'b0;
            op_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        opcode_q   <= instr[OPC_LSB +: 4];
                        escalar_q  <= instr[ESC_LSB +: 8];
                        base_a_q   <= instr[BA_LSB +: 8];
                        base_b_q   <= instr[BB_LSB +: 8];
                        base_r_q   <= instr[BR_LSB +: 8];
                        // First read goes out in the cycle right after accept.
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= instr[BA_LSB +: 8];
                        rd_cnt_q   <= CW'(1);
                        cap_cnt_q  <= '0;
                        rd_vld_q   <= 1'b0;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    rd_vld_q <= mem_rd_q;
                    if (rd_cnt_q < CW'(2 * N)) begin
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= rd_addr_d;
                        rd_cnt_q   <= rd_cnt_q + CW'(1);
                    end else begin
                        mem_rd_q <= 1'b0;
                    end
                    if (rd_vld_q) begin
                        cap_cnt_q <= cap_cnt_q + CW'(1);
                        if (cap_cnt_q == CW'(2 * N - 1)) begin
                            tmr_q <= '0;
                            // A done still high from the ULA must fall before start rises.
                            if (ula_done) begin
                                state_q <= WAIT;
                            end else begin
                                ula_start_q <= 1'b1;
                                state_q     <= EXEC;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!ula_done) begin
                        ula_start_q <= 1'b1;
                        tmr_q       <= '0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    if (ula_done) begin
                        ula_start_q <= 1'b0;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= base_r_q;
                        st_idx_q    <= '0;
                        state_q     <= STORE;
                    end else if (tmr_q == TW'(TIMEOUT - 1)) begin
                        ula_start_q <= 1'b0;
                        op_err_q    <= 1'b1;
                        state_q     <= FINISH;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                STORE: begin
                    if (st_idx_q == IDXW'(N - 1)) begin
                        mem_wr_q  <= 1'b0;
                        op_done_q <= 1'b1;
                        state_q   <= FINISH;
                    end else begin
                        st_idx_q   <= st_idx_q + IDXW'(1);
                        mem_addr_q <= base_r_q + 8'(st_idx_q) + 8'd1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_q == IDLE) && !ula_done;
    assign busy        = !instr_ready;
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign ula_opcode  = opcode_q;
    assign ula_escalar = escalar_q;
    assign ula_start   = ula_start_q;
    assign op_done     = op_done_q;
    assign op_err      = op_err_q;

endmodule

// File: tb/tb_ula_controller.sv
// tb/tb_ula_controller.sv - directed self-checking bench for ula_controller
module tb_ula_controller;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam logic [39:0] ONES  = 40'h0101010101;
    localparam logic [39:0] TWOS  = 40'h0202020202;
    localparam logic [39:0] THREE = 40'h0303030303;
    localparam logic [39:0] SENT  = 40'hDEADBEEF55;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_valid;
    logic         instr_ready;
    logic [35:0]  instr;
    logic [7:0]   mem_addr;
    logic         mem_rd;
    logic         mem_wr;
    logic [39:0]  mem_rdata;
    logic [39:0]  mem_wdata;
    logic [3:0]   ula_opcode;
    logic [7:0]   ula_escalar;
    logic         ula_start;
    logic [199:0] ula_matrizA;
    logic [199:0] ula_matrizB;
    logic [199:0] ula_res;
    logic         ula_done = 1'b0;
    logic         busy;
    logic         op_done;
    logic         op_err;

    ula_controller #(.N(N), .DW(DW), .TIMEOUT(10)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .instr_valid           (instr_valid),
        .instr_ready           (instr_ready),
        .instr                 (instr),
        .mem_addr              (mem_addr),
        .mem_rd                (mem_rd),
        .mem_wr                (mem_wr),
        .mem_rdata             (mem_rdata),
        .mem_wdata             (mem_wdata),
        .ula_opcode            (ula_opcode),
        .ula_escalar           (ula_escalar),
        .ula_start             (ula_start),
        .ula_matrizA           (ula_matrizA),
        .ula_matrizB           (ula_matrizB),
        .ula_matriz_resultante (ula_res),
        .ula_done              (ula_done),
        .busy                  (busy),
        .op_done               (op_done),
        .op_err                (op_err)
    );

    always #5 clk = ~clk;

    // Row memory: registered read, bench preload port when the DUT is not writing.
    logic [39:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_wa = 8'd0;
    logic [39:0] tb_wd = 40'd0;
    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_wa] <= tb_wd;
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    // ULA model: elementwise A+B, done raised lat cycles after start, for one cycle.
    int lat = 1;
    bit never = 1'b0;
    int ucnt = 0;
    always_comb begin
        ula_res = '0;
        for (int i = 0; i < N * N; i++) ula_res[i*8 +: 8] = ula_matrizA[i*8 +: 8] + ula_matrizB[i*8 +: 8];
    end
    always @(posedge clk) begin
        if (!ula_start || ula_done) begin
            ucnt     <= 0;
            ula_done <= 1'b0;
        end else if (!never && ucnt == lat - 1) begin
            ula_done <= 1'b1;
        end else begin
            ucnt <= ucnt + 1;
        end
    end

    // Monitor, sampled mid-cycle.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
    int rd_n = 0, wr_n = 0, overlap = 0, start_wait = 0, bad_rise = 0;
    logic [7:0] rd_log [512];
    logic start_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready) begin acc_cnt++; acc_cyc = cyc; end
            if (op_done) begin done_cnt++; done_cyc = cyc; end
            if (op_err) begin err_cnt++; err_cyc = cyc; end
            if (mem_rd) begin rd_log[rd_n[8:0]] = mem_addr; rd_n++; end
            if (mem_wr) wr_n++;
            if (mem_rd && mem_wr) overlap++;
            if (ula_start && !ula_done) start_wait++;
            if (ula_start && !start_prev && ula_done) bad_rise++;
            start_prev = ula_start;
        end
    end

    int passed = 0, total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [35:0] mk(input logic [3:0] op, input logic [7:0] esc,
                                       input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] br);
        return {br, bb, ba, esc, op};
    endfunction

    function automatic logic [39:0] mkrow(input logic [7:0] base);
        logic [39:0] r;
        for (int j = 0; j < N; j++) r[j*8 +: 8] = base + 8'(j);
        return r;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [39:0] d);
        @(posedge clk); #1;
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic [35:0] ins);
        int k;
        @(posedge clk); #1;
        instr = ins; instr_valid = 1'b1;
        k = 0;
        while (!instr_ready && k < 100) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_op(input int d0, input int e0);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            if (done_cnt + err_cnt != d0 + e0) break;
        end
        check("op_completes", 64'(done_cnt + err_cnt - d0 - e0), 64'd1);
    endtask

    int d0, e0, a0, r0, w0, s0, n, gap;
    logic [7:0] exp_a [6];

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_ula_start", 64'(ula_start), 64'd0);
        check("rst_op_done_err", 64'({op_done, op_err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_instr_ready", 64'(instr_ready), 64'd1);

        for (int r = 0; r < N; r++) begin
            poke(8'h10 + 8'(r), ONES);
            poke(8'h20 + 8'(r), TWOS);
            poke(8'hFE + 8'(r), mkrow(8'(8'h10 * r)));
            poke(8'h80 + 8'(r), ONES);
            poke(8'h60 + 8'(r), SENT);
        end

        // Case 1: A=1s, B=2s, 1-cycle ULA
        d0 = done_cnt; e0 = err_cnt; r0 = rd_n; w0 = wr_n; s0 = start_wait;
        issue(mk(4'd3, 8'h5A, 8'h10, 8'h20, 8'h40));
        wait_op(d0, e0);
        check("c1_op_done_latency", 64'(done_cyc - acc_cyc), 64'd19);
        for (int r = 0; r < N; r++) check($sformatf("c1_row%0d", r), 64'(mem[8'h40 + 8'(r)]), 64'(THREE));
        check("c1_writes", 64'(wr_n - w0), 64'd5);
        check("c1_reads", 64'(rd_n - r0), 64'd10);
        check("c1_rd_addr5", 64'(rd_log[r0 + 5]), 64'h20);
        check("c1_opcode", 64'(ula_opcode), 64'd3);
        check("c1_escalar", 64'(ula_escalar), 64'h5A);
        check("c1_start_cycles", 64'(start_wait - s0), 64'd1);

        // Case 2: base_a wraps past 0xFF, distinct row contents
        d0 = done_cnt; e0 = err_cnt; r0 = rd_n;
        issue(mk(4'd4, 8'h00, 8'hFE, 8'h80, 8'h50));
        wait_op(d0, e0);
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00;
        exp_a[3] = 8'h01; exp_a[4] = 8'h02; exp_a[5] = 8'h80;
        for (int i = 0; i < 6; i++) check($sformatf("c2_rd_addr%0d", i), 64'(rd_log[r0 + i]), 64'(exp_a[i]));
        for (int r = 0; r < N; r++)
            check($sformatf("c2_row%0d", r), 64'(mem[8'h50 + 8'(r)]), 64'(mkrow(8'(8'h10 * r + 1))));
        check("c2_opcode", 64'(ula_opcode), 64'd4);

        // Case 3: ULA never completes, timeout of 10
        never = 1'b1;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_n; s0 = start_wait;
        issue(mk(4'd1, 8'h00, 8'h10, 8'h20, 8'h60));
        wait_op(d0, e0);
        check("c3_err_pulse", 64'(err_cnt - e0), 64'd1);
        check("c3_no_done", 64'(done_cnt - d0), 64'd0);
        check("c3_no_writes", 64'(wr_n - w0), 64'd0);
        check("c3_err_latency", 64'(err_cyc - acc_cyc), 64'd22);
        check("c3_start_cycles", 64'(start_wait - s0), 64'd10);
        @(negedge clk);
        check("c3_ready", 64'(instr_ready), 64'd1);
        check("c3_start_low", 64'(ula_start), 64'd0);
        check("c3_mem_untouched", 64'(mem[8'h60]), 64'(SENT));
        never = 1'b0;

        // Case 4: instr_valid held high across an operation
        d0 = done_cnt; a0 = acc_cnt;
        @(posedge clk); #1;
        instr = mk(4'd3, 8'h00, 8'h10, 8'h20, 8'h70); instr_valid = 1'b1;
        for (int k = 0; k < 200 && done_cnt == d0; k++) @(posedge clk);
        check("c4_single_accept", 64'(acc_cnt - a0), 64'd1);
        for (int k = 0; k < 50 && acc_cnt != a0 + 2; k++) @(posedge clk);
        #1 instr_valid = 1'b0;
        gap = acc_cyc - done_cyc;
        check("c4_second_after_done", 64'(gap), 64'd1);
        wait_op(d0 + 1, err_cnt);
        check("c4_total_accepts", 64'(acc_cnt - a0), 64'd2);
        check("c4_row0", 64'(mem[8'h70]), 64'(THREE));

        // Case 5: reset during STORE after two writes have committed
        issue(mk(4'd3, 8'h00, 8'h10, 8'h20, 8'h60));
        n = 0;
        for (int k = 0; k < 100 && n < 3; k++) begin @(negedge clk); if (mem_wr) n++; end
        #1 rst_n = 1'b0;
        #1;
        check("c5_mem_wr_low", 64'(mem_wr), 64'd0);
        check("c5_busy_low", 64'(busy), 64'd0);
        check("c5_start_low", 64'(ula_start), 64'd0);
        d0 = done_cnt; e0 = err_cnt;
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("c5_row0_written", 64'(mem[8'h60]), 64'(THREE));
        check("c5_row1_written", 64'(mem[8'h61]), 64'(THREE));
        check("c5_row2_aborted", 64'(mem[8'h62]), 64'(SENT));
        check("c5_no_pulses", 64'(done_cnt - d0 + err_cnt - e0), 64'd0);
        issue(mk(4'd3, 8'h00, 8'h10, 8'h20, 8'h62));
        wait_op(d0, e0);
        check("c5_rerun_latency", 64'(done_cyc - acc_cyc), 64'd19);
        check("c5_rerun_row2", 64'(mem[8'h62]), 64'(THREE));

        // Case 6: ULA done latency of 7 cycles
        lat = 7;
        d0 = done_cnt; e0 = err_cnt; s0 = start_wait;
        issue(mk(4'd3, 8'h00, 8'h10, 8'h20, 8'h90));
        wait_op(d0, e0);
        check("c6_op_done_latency", 64'(done_cyc - acc_cyc), 64'd25);
        check("c6_start_cycles", 64'(start_wait - s0), 64'd7);
        check("c6_row0", 64'(mem[8'h90]), 64'(THREE));
        check("c6_row4", 64'(mem[8'h94]), 64'(THREE));

        check("rd_wr_overlap", 64'(overlap), 64'd0);
        check("start_rise_on_done", 64'(bad_rise), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ula_controller.md
ULA_CONTROLLER -- requirements
Module: ula_controller

Interface
REQ-001 Parameter N, default 5, matrix dimension; matrix = N*N elements.
REQ-002 Parameter DW, default 8, element width; row = N*DW bits, matrix = N*N*DW bits (200 by default).
REQ-003 Parameter TIMEOUT, default 255, max cycles to wait for ula_done.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 instr_valid/instr_ready  in/out  1/1  instruction handshake.
REQ-007 instr  in  36  [3:0] opcode, [11:4] escalar, [19:12] base_a, [27:20] base_b, [35:28] base_r.
REQ-008 mem_addr/mem_rd/mem_wr  out  8/1/1  row-memory address and strobes.
REQ-009 mem_rdata/mem_wdata  in/out  N*DW each  row data; read data is valid the cycle after mem_rd.
REQ-010 ula_opcode/ula_escalar/ula_start  out  4/8/1  ULA controls.
REQ-011 ula_matrizA/ula_matrizB  out  N*N*DW each  operands.
REQ-012 ula_matriz_resultante/ula_done  in  N*N*DW/1  ULA result and completion.
REQ-013 busy/op_done/op_err  out  1/1/1  status; op_done and op_err are 1-cycle pulses.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, EXEC, WAIT, STORE, FINISH.
REQ-015 instr_ready SHALL be 1 only in IDLE with ula_done=0; busy = !instr_ready.
REQ-016 Accept (cycle 0) SHALL latch all instr fields; instr_valid while busy is ignored, not queued.
REQ-017 LOAD SHALL issue mem_rd in cycles 1..2N: addresses base_a+0..N-1, then base_b+0..N-1; base+r wraps modulo 256.
REQ-018 Row r data SHALL be written to matrix bits [r*N*DW +: N*DW]; element j of the row at [j*DW +: DW].
REQ-019 EXEC SHALL assert ula_start from cycle 2N+2 (cycle 12 at N=5), operands and opcode/escalar stable while high.
REQ-020 ula_start SHALL stay high until ula_done=1 is sampled; the result is captured in that cycle and ula_start drops the next cycle.
REQ-021 ula_start SHALL never rise while ula_done=1.
REQ-022 STORE SHALL assert mem_wr on N consecutive cycles starting the cycle after capture, addresses base_r+0..N-1, mem_wdata = result row r.
REQ-023 FINISH SHALL pulse op_done for one cycle, then return to IDLE.
REQ-024 With a 1-cycle ULA, op_done SHALL occur at cycle 4N-1 after accept (cycle 19 at N=5).
REQ-025 If ula_done is not seen within TIMEOUT cycles of ula_start rising, the block SHALL drop ula_start, pulse op_err (no op_done), skip STORE, and return to IDLE.
REQ-026 mem_rd and mem_wr SHALL never be asserted in the same cycle.
REQ-027 Opcode is passed through unchanged; the controller SHALL NOT decode it.

Reset
REQ-028 rst_n low SHALL immediately force IDLE and zero all outputs and registers (mem_rd, mem_wr, ula_start, op_done, op_err, busy = 0; instr_ready = 1 after release unless ula_done=1).
REQ-029 Reset mid-operation SHALL abort without completing pending writes; no op_done or op_err pulse is produced.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, instr field offsets, and N/DW defaults.
REQ-031 A single sub-module, ula_row_packer (row index plus row data into matrix register with write enable), SHALL be instantiated for operand A, operand B, and result unpacking.

Verification
REQ-032 Case 1: mem A=all 1, B=all 2, opcode 3, 1-cycle ULA model -> rows base_r..+4 written 0x0303030303; op_done at cycle 19.
REQ-033 Case 2: base_a=0xFE -> reads at 0xFE, 0xFF, 0x00, 0x01, 0x02.
REQ-034 Case 3: ULA model never raises done, TIMEOUT=10 -> op_err pulse, no mem_wr, instr_ready back to 1.
REQ-035 Case 4: instr_valid held high during an operation -> exactly one accept; second instruction accepted only after op_done.
REQ-036 Case 5: rst_n low during STORE after 2 writes -> mem_wr=0 immediately; no op_done; a new instruction runs to completion.
REQ-037 Case 6: ULA done latency of 7 cycles -> ula_start held 7 cycles; op_done shifted by +6 versus Case 1.
